// File: rtl/uart_mm_slave_if.sv
// Bus bundle between the address decoder (master) and the UART window (slave).
// There is no handshake: an access is a single cycle. HSel marks the cycle as
// addressed to this peripheral (read), HSel&WSel marks a write that takes
// effect at the closing clock edge, and HRData is valid combinationally
// within the same cycle. No side takes a ready/stall.
interface uart_mm_slave_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  HSel;
    logic                  WSel;
    logic [DATA_WIDTH-1:0] map_Address;
    logic [DATA_WIDTH-1:0] map_Data;
    logic [DATA_WIDTH-1:0] HRData;

    modport master (
        output HSel,
        output WSel,
        output map_Address,
        output map_Data,
        input  HRData
    );

    modport slave (
        input  HSel,
        input  WSel,
        input  map_Address,
        input  map_Data,
        output HRData
    );
endinterface

// File: rtl/uart_mm_slave.sv
// Memory-mapped 8N1 UART: TX/RX data and status registers behind a one-cycle
// bus. Word 0 TX_DATA, 1 TX_STATUS, 2 RX_DATA, 3 RX_STATUS.
module uart_mm_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int BAUD_DIV   = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_mm_slave_if.slave   bus,
    input  logic             uart_rx,
    output logic             uart_tx,
    output logic [1:0]       tx_fsm_state,
    output logic [1:0]       rx_fsm_state
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode
    logic       wr_en;
    logic [3:0] idx;
    logic       tx_wr;
    logic       tx_stat_wr;
    logic       rx_clr;

    assign wr_en      = bus.HSel & bus.WSel;
    assign idx        = bus.map_Address[3:0];
    assign tx_wr      = wr_en && (idx == 4'd0);
    assign tx_stat_wr = wr_en && (idx == 4'd1);
    assign rx_clr     = wr_en && (idx == 4'd3) && bus.map_Data[0];

    logic unused_bits;
    assign unused_bits = ^{bus.map_Address[DATA_WIDTH-1:4], bus.map_Data[DATA_WIDTH-1:8]};

    // ---------------- Transmitter ----------------
    state_t        tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic          tx_ovr, tx_ovr_n;
    logic          tx_busy;

    assign tx_busy = (tx_state != S_IDLE);

    // TX state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_ovr   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_shift <= tx_shift_n;
            tx_bit   <= tx_bit_n;
            tx_ovr   <= tx_ovr_n;
        end
    end

    // TX next state: one bit per BAUD_DIV cycles, counter reloaded per bit
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_shift_n = tx_shift;
        tx_bit_n   = tx_bit;
        tx_ovr_n   = tx_ovr;
        unique case (tx_state)
            S_IDLE: begin
                if (tx_wr) begin
                    tx_state_n = S_START;
                    tx_cnt_n   = BIT_LOAD;
                    tx_shift_n = bus.map_Data[7:0];
                    tx_bit_n   = '0;
                end
            end
            S_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = BIT_LOAD;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n   = BIT_LOAD;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_n = S_STOP;
                    else                tx_bit_n   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            S_STOP: begin
                if (tx_cnt == '0) tx_state_n = S_IDLE;
                else              tx_cnt_n   = tx_cnt - CNT_ONE;
            end
            default: tx_state_n = S_IDLE;
        endcase
        // A data write while busy (including the last STOP cycle) is dropped
        if (tx_stat_wr)          tx_ovr_n = 1'b0;
        else if (tx_wr && tx_busy) tx_ovr_n = 1'b1;
    end

    // Serial line follows the frame position; LSB of shifter is current bit
    always_comb begin
        uart_tx = 1'b1;
        case (tx_state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = tx_shift[0];
            default: uart_tx = 1'b1;
        endcase
    end

    // ---------------- Receiver ----------------
    logic          rx_s1, rx_s2;
    state_t        rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_data, rx_data_n;
    logic          rx_valid, rx_valid_n;
    logic          frame_err, frame_err_n;
    logic          rx_ovr, rx_ovr_n;
    logic          done_ok;
    logic          done_bad;

    // Two-flop synchronizer for the asynchronous pin, reset to idle-high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
        end
    end

    // RX state and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_shift  <= '0;
            rx_bit    <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_ovr    <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_shift  <= rx_shift_n;
            rx_bit    <= rx_bit_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            rx_ovr    <= rx_ovr_n;
        end
    end

    // RX next state: half-bit delay to centre, then sample every bit period;
    // a byte completing in the same cycle as a status clear takes priority
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_shift_n  = rx_shift;
        rx_bit_n    = rx_bit;
        rx_data_n   = rx_data;
        rx_valid_n  = rx_valid;
        frame_err_n = frame_err;
        rx_ovr_n    = rx_ovr;
        done_ok     = 1'b0;
        done_bad    = 1'b0;
        unique case (rx_state)
            S_IDLE: begin
                if (!rx_s2) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = HALF_LOAD;
                end
            end
            S_START: begin
                if (rx_cnt == '0) begin
                    if (!rx_s2) begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = BIT_LOAD;
                        rx_bit_n   = '0;
                    end else begin
                        rx_state_n = S_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_cnt_n   = BIT_LOAD;
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            S_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = S_IDLE;
                    done_ok    = rx_s2;
                    done_bad   = !rx_s2;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
        if (rx_clr) begin
            rx_valid_n  = 1'b0;
            frame_err_n = 1'b0;
            rx_ovr_n    = 1'b0;
        end
        if (done_ok) begin
            rx_data_n  = rx_shift;
            rx_valid_n = 1'b1;
            if (rx_valid && !rx_clr) rx_ovr_n = 1'b1;
        end
        if (done_bad) frame_err_n = 1'b1;
    end

    // ---------------- Read mux ----------------
    logic [DATA_WIDTH-1:0] rd_data;

    // Combinational read of the addressed register, zero when not selected
    always_comb begin
        rd_data = '0;
        if (bus.HSel) begin
            case (idx)
                4'd1:    rd_data[1:0] = {tx_ovr, tx_busy};
                4'd2:    rd_data[7:0] = rx_data;
                4'd3:    rd_data[2:0] = {rx_ovr, frame_err, rx_valid};
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.HRData   = rd_data;
    assign tx_fsm_state = tx_state;
    assign rx_fsm_state = rx_state;

endmodule

// File: tb/tb_uart_mm_slave.sv
// Directed bench for uart_mm_slave with BAUD_DIV=4: a driver issues one bus
// cycle per step and queues expected read data / serial line values; a
// negedge monitor pops and compares.
module tb_uart_mm_slave;

    localparam int W  = 32;
    localparam int BD = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    uart_mm_slave_if #(.DATA_WIDTH(W)) bus ();

    logic       rx_drive;
    logic       loopback;
    logic       rx_line;
    logic       uart_tx;
    logic [1:0] tx_fsm_state;
    logic [1:0] rx_fsm_state;

    assign rx_line = loopback ? uart_tx : rx_drive;

    uart_mm_slave #(.DATA_WIDTH(W), .BAUD_DIV(BD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .uart_rx      (rx_line),
        .uart_tx      (uart_tx),
        .tx_fsm_state (tx_fsm_state),
        .rx_fsm_state (rx_fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        rd_name_q[$];
    logic [0:0]   tx_exp_q[$];
    string        tx_name_q[$];
    logic         chk_rd;
    logic         chk_tx;
    int           n_checks;
    int           n_fail;

    always @(negedge clk) begin
        if (chk_rd) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_queue: HRData=0x%0h but no expected value queued", bus.HRData);
            end else begin
                logic [W-1:0] e;
                string        nm;
                e  = exp_q.pop_front();
                nm = rd_name_q.pop_front();
                if (bus.HRData !== e) begin
                    n_fail++;
                    $display("FAIL %s: HRData=0x%0h expected 0x%0h at %0t", nm, bus.HRData, e, $time);
                end
            end
        end
        if (chk_tx) begin
            n_checks++;
            if (tx_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_queue: uart_tx=%b but no expected value queued", uart_tx);
            end else begin
                logic [0:0] e;
                string      nm;
                e  = tx_exp_q.pop_front();
                nm = tx_name_q.pop_front();
                if (uart_tx !== e[0]) begin
                    n_fail++;
                    $display("FAIL %s: uart_tx=%b expected %b at %0t", nm, uart_tx, e[0], $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One bus cycle; caller is positioned just after a rising edge.
    task automatic step(input logic hsel, input logic wsel, input logic [3:0] idx,
                        input logic [W-1:0] data, input logic do_rd, input logic [W-1:0] rd_exp,
                        input logic do_tx, input logic tx_exp, input string name);
        bus.HSel        = hsel;
        bus.WSel        = wsel;
        bus.map_Address = {28'd0, idx};
        bus.map_Data    = data;
        chk_rd          = do_rd;
        chk_tx          = do_tx;
        if (do_rd) begin
            exp_q.push_back(rd_exp);
            rd_name_q.push_back(name);
        end
        if (do_tx) begin
            tx_exp_q.push_back(tx_exp);
            tx_name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        chk_rd   = 1'b0;
        chk_tx   = 1'b0;
        bus.HSel = 1'b0;
        bus.WSel = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, '0, 1'b0, '0, 1'b0, 1'b0, "idle");
    endtask

    task automatic rd(input logic [3:0] idx, input logic [W-1:0] e, input string name);
        step(1'b1, 1'b0, idx, '0, 1'b1, e, 1'b0, 1'b0, name);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [W-1:0] d);
        step(1'b1, 1'b1, idx, d, 1'b0, '0, 1'b0, 1'b0, "write");
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drive = f[i];
            idle(BD);
        end
        rx_drive = 1'b1;
        idle(6);
    endtask

    // TX frame check; optional mid-frame overrun write and overrun clear
    task automatic tx_frame(input logic [7:0] b, input logic with_ovr);
        logic [9:0] f;
        logic [W-1:0] st;
        f = {1'b1, b, 1'b0};
        step(1'b1, 1'b1, 4'd0, {24'd0, b}, 1'b0, '0, 1'b1, 1'b1, "tx_write_idle_line");
        for (int k = 0; k < 10 * BD; k++) begin
            if (with_ovr && k == 10)
                step(1'b1, 1'b1, 4'd0, 32'h5A, 1'b0, '0, 1'b1, f[k / BD], "tx_ovr_write_line");
            else if (with_ovr && k == 20)
                step(1'b1, 1'b1, 4'd1, '0, 1'b0, '0, 1'b1, f[k / BD], "tx_ovr_clear_line");
            else begin
                st = (with_ovr && k > 10 && k < 20) ? 32'h3 : 32'h1;
                step(1'b1, 1'b0, 4'd1, '0, 1'b1, st, 1'b1, f[k / BD], "tx_frame_status_line");
            end
        end
        step(1'b1, 1'b0, 4'd1, '0, 1'b1, 32'h0, 1'b1, 1'b1, "tx_done_status_line");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks        = 0;
        n_fail          = 0;
        chk_rd          = 1'b0;
        chk_tx          = 1'b0;
        rx_drive        = 1'b1;
        loopback        = 1'b0;
        bus.HSel        = 1'b0;
        bus.WSel        = 1'b0;
        bus.map_Address = '0;
        bus.map_Data    = '0;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        step(1'b1, 1'b0, 4'd1, '0, 1'b1, 32'h0, 1'b1, 1'b1, "reset_tx_status");
        rd(4'd3, 32'h0, "reset_rx_status");
        rd(4'd2, 32'h0, "reset_rx_data");
        n_checks++;
        if (tx_fsm_state !== 2'd0 || rx_fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_fsm_state: tx=%0d rx=%0d expected 0 0", tx_fsm_state, rx_fsm_state);
        end

        // Plain TX frame of 0xA5, then one with overrun write and clear
        tx_frame(8'hA5, 1'b0);
        tx_frame(8'hA5, 1'b1);

        // Unmapped / write-only reads
        wr(4'd5, 32'hFFFF_FFFF);
        rd(4'd0, 32'h0, "rd_tx_data_zero");
        rd(4'd5, 32'h0, "rd_idx5_zero");
        rd(4'd15, 32'h0, "rd_idx15_zero");

        // RX good frame and clear
        send_frame(8'h3C, 1'b1);
        rd(4'd2, 32'h3C, "rx_data_3c");
        rd(4'd3, 32'h1, "rx_status_valid");
        wr(4'd3, 32'h0);
        rd(4'd3, 32'h1, "rx_clear_bit0_zero_ignored");
        wr(4'd3, 32'h1);
        rd(4'd3, 32'h0, "rx_status_cleared");

        // Framing error leaves data unchanged
        send_frame(8'h81, 1'b0);
        rd(4'd3, 32'h2, "rx_frame_err");
        rd(4'd2, 32'h3C, "rx_data_kept");
        wr(4'd3, 32'h1);

        // Overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd(4'd2, 32'h22, "rx_data_22");
        rd(4'd3, 32'h5, "rx_overrun");
        step(1'b0, 1'b0, 4'd2, '0, 1'b1, 32'h0, 1'b0, 1'b0, "hsel_low_reads_zero");
        wr(4'd3, 32'h1);
        rd(4'd3, 32'h0, "rx_status_cleared2");

        // Short glitch rejected
        rx_drive = 1'b0;
        idle(1);
        rx_drive = 1'b1;
        idle(20);
        rd(4'd3, 32'h0, "rx_glitch_no_flags");
        rd(4'd2, 32'h22, "rx_glitch_data_kept");

        // Loopback
        loopback = 1'b1;
        wr(4'd0, 32'hC3);
        idle(50);
        rd(4'd2, 32'hC3, "loop_rx_data");
        rd(4'd3, 32'h1, "loop_rx_status");
        wr(4'd3, 32'h1);

        // Reset in the middle of a looped-back frame
        wr(4'd0, 32'h55);
        idle(15);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 4'd1, '0, 1'b1, 32'h0, 1'b1, 1'b1, "reset_mid_frame_tx");
        idle(50);
        rd(4'd3, 32'h0, "reset_mid_frame_rx_status");
        rd(4'd2, 32'h0, "reset_mid_frame_rx_data");

        n_checks++;
        if (exp_q.size() != 0 || tx_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: rd=%0d tx=%0d left, expected 0 0", exp_q.size(), tx_exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
